// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared types and constants for the instruction-memory boot
//               loader: loader state encoding, default memory geometry and
//               the width of the stream's word-count header.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    localparam int DEPTH_DEFAULT  = 1024;  // instruction memory depth, words
    localparam int ADDR_W_DEFAULT = 10;    // log2(DEPTH_DEFAULT)
    localparam int HDR_W          = 16;    // word-count header width, bits

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        FIN    = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Packs a little-endian byte stream into 32-bit words. Bytes
//               shift in from the top, so after four bytes the first one sits
//               in [7:0] and the fourth in [31:24].
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               clear           - zero the byte counter and partial word
//               byte_en         - a stream byte is consumed this cycle
//               byte_data[7:0]  - the stream byte
//               word_done       - this byte completes a word (combinational)
//               word[31:0]      - word including the current byte
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_done,
    output logic [31:0] word
);

    logic [1:0]  cnt_q,  cnt_d;
    logic [31:0] word_q, word_d;

    // The word is presented combinationally with the completing byte merged
    // in, so the caller can register it on the same edge that accepts it.
    assign word      = {byte_data, word_q[31:8]};
    assign word_done = byte_en & ~clear & (cnt_q == 2'd3);

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear) begin
            cnt_d  = 2'd0;
            word_d = 32'd0;
        end else if (byte_en) begin
            cnt_d  = cnt_q + 2'd1;   // wraps 3 -> 0 at each word boundary
            word_d = {byte_data, word_q[31:8]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time loader. Receives a 16-bit little-endian word count
//               followed by that many little-endian 32-bit words, writes them
//               to instruction memory from address 0, and holds the core in
//               reset until the final write has committed.
// Ports       : clk, rst             - clock, asynchronous active-high reset
//               start                - pulse to begin a load (ignored if busy)
//               byte_valid/byte_data - incoming stream byte
//               byte_ready           - byte accepted this cycle
//               wr_en/wr_addr/wr_data- registered memory write port
//               core_hold            - core reset hold, low only when loaded
//               busy / done / err    - load status
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        core_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [HDR_W-1:0] c_DEPTH_LEN = HDR_W'(DEPTH);

    state_t             state_q, state_d;
    logic [HDR_W-1:0]   len_q,   len_d;
    logic [ADDR_W:0]    k_q,     k_d;     // one spare bit: k never wraps
    logic               wr_en_q, wr_en_d;
    logic [31:0]        wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;

    logic               w_accept;
    logic               w_asm_clear;
    logic               w_asm_en;
    logic               w_word_done;
    logic [31:0]        w_word;
    logic [HDR_W-1:0]   w_len_next;
    logic [HDR_W-1:0]   w_k_ext;
    logic [HDR_W-1:0]   w_last_idx;

    assign w_accept   = byte_valid & byte_ready;
    assign w_asm_en   = w_accept & (state_q == DATA);
    assign w_len_next = {byte_data, len_q[7:0]};
    assign w_k_ext    = {{(HDR_W-ADDR_W-1){1'b0}}, k_q};
    assign w_last_idx = len_q - {{(HDR_W-1){1'b0}}, 1'b1};

    word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_asm_clear),
        .byte_en   (w_asm_en),
        .byte_data (byte_data),
        .word_done (w_word_done),
        .word      (w_word)
    );

    // Next-state and status outputs
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        k_d         = k_q;
        w_asm_clear = 1'b0;
        byte_ready  = 1'b0;
        busy        = 1'b0;
        core_hold   = 1'b1;
        done        = 1'b0;
        err         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = LEN_LO;
            end
            LEN_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_accept) begin
                    len_d[7:0] = byte_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_accept) begin
                    len_d = w_len_next;
                    if (w_len_next == '0 || w_len_next > c_DEPTH_LEN) begin
                        state_d = ERR;
                    end else begin
                        state_d     = DATA;
                        k_d         = '0;
                        w_asm_clear = 1'b1;
                    end
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_word_done) begin
                    if (w_k_ext == w_last_idx) state_d = FIN;
                    else                       k_d     = k_q + 1'b1;
                end
            end
            FIN: begin
                // Last write is on the bus this cycle; release the core only
                // after it has committed.
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                core_hold = 1'b0;
                done      = 1'b1;
                if (start) state_d = LEN_LO;
            end
            ERR: begin
                err = 1'b1;
                if (start) state_d = LEN_LO;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered write port: strobe, address and data all appear in the cycle
    // after the edge that accepts a word's fourth byte.
    always_comb begin
        wr_en_d   = w_word_done;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (w_word_done) begin
            wr_addr_d = {{(32-ADDR_W-3){1'b0}}, k_q, 2'b00};
            wr_data_d = w_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            k_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 32'd0;
            wr_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            k_q       <= k_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Streams are built as
//               byte queues; a reference model derives the expected memory
//               writes from the stream contents and a negedge monitor checks
//               every write strobe against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic [7:0] s[$];       // stream under test
    wr_t        exp_q[$];   // writes the model predicts
    wr_t        act_q[$];   // writes observed on the bus
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b, required %b at %0t", name, act, req, $time);
        end
    endtask

    // Model: a header N followed by as many complete words as were streamed
    // (capped at N) produces one write per word at 4*k. Rejected lengths
    // produce nothing.
    task automatic model_push();
        int n;
        int full;
        if (s.size() < 2) return;
        n = int'({s[1], s[0]});
        if (n == 0 || n > DEPTH) return;
        full = (s.size() - 2) / 4;
        if (full > n) full = n;
        for (int k = 0; k < full; k++) begin
            wr_t w;
            w.a = 32'(4 * k);
            w.d = {s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]};
            exp_q.push_back(w);
        end
    endtask

    task automatic build_words(input int n, input logic [31:0] seed);
        logic [31:0] w;
        logic [15:0] nn;
        s.delete();
        nn = 16'(n);
        s.push_back(nn[7:0]);
        s.push_back(nn[15:8]);
        for (int k = 0; k < n; k++) begin
            w = (32'(k) * 32'h0100_0193) ^ seed;
            s.push_back(w[7:0]);
            s.push_back(w[15:8]);
            s.push_back(w[23:16]);
            s.push_back(w[31:24]);
        end
    endtask

    // Called and returns at posedge+1. Holds byte_valid; the byte is taken on
    // the first edge at which byte_ready is high.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        forever begin
            @(negedge clk);
            if (byte_ready) break;
            waited++;
            if (waited > 50) begin
                check1("byte_accept_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_stream(input bit gaps, input int start_at);
        model_push();
        for (int i = 0; i < s.size(); i++) begin
            if (gaps && i > 0 && $urandom_range(0, 1) == 1) begin
                byte_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            if (i == start_at) start = 1'b1;
            send_byte(s[i]);
            start = 1'b0;
        end
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // At posedge+1 following the last data byte: FIN, then DONE.
    task automatic finish_load(input string tag);
        check1({tag, "_fin_busy"}, busy, 1'b1);
        check1({tag, "_fin_hold"}, core_hold, 1'b1);
        check1({tag, "_fin_wr_en"}, wr_en, 1'b1);
        @(posedge clk);
        #1;
        check1({tag, "_done"}, done, 1'b1);
        check1({tag, "_done_hold"}, core_hold, 1'b0);
        check1({tag, "_done_busy"}, busy, 1'b0);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every strobe must match the next predicted write.
    always @(negedge clk) begin : mon
        wr_t e;
        if (wr_en === 1'b1) begin
            e.a = wr_addr;
            e.d = wr_data;
            act_q.push_back(e);
            if (exp_q.size() == 0) begin
                check1("unexpected_wr_en", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", wr_addr, e.a);
                check("wr_data", wr_data, e.d);
            end
        end
        check1("hold_vs_done", core_hold, ~done);
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check1("rst_byte_ready", byte_ready, 1'b0);
        check1("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_addr", wr_addr, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check1("rst_core_hold", core_hold, 1'b1);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);

        // start coincident with reset is lost
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        check1("rst_wins_busy", busy, 1'b0);

        // basic two-word load
        pulse_start();
        check1("t1_busy", busy, 1'b1);
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h33, 8'hE2, 8'h62, 8'h00};
        act_q.delete();
        send_stream(1'b0, -1);
        check("t1_fin_addr", wr_addr, 32'h4);
        finish_load("t1");
        check("t1_nwr", 32'(act_q.size()), 32'd2);
        if (act_q.size() == 2) begin
            check("t1_a0", act_q[0].a, 32'h0);
            check("t1_d0", act_q[0].d, 32'h0000_0013);
            check("t1_a1", act_q[1].a, 32'h4);
            check("t1_d1", act_q[1].d, 32'h0062_E233);
        end

        // zero length rejected, then a valid reload
        pulse_start();
        s = '{8'h00, 8'h00};
        act_q.delete();
        send_stream(1'b0, -1);
        check1("t2_err", err, 1'b1);
        check1("t2_hold", core_hold, 1'b1);
        check1("t2_busy", busy, 1'b0);
        check1("t2_ready", byte_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check1("t2_err_stays", err, 1'b1);
        check("t2_nwr", 32'(act_q.size()), 32'd0);
        pulse_start();
        check1("t2_err_cleared", err, 1'b0);
        build_words(3, 32'hDEAD_BEEF);
        send_stream(1'b0, -1);
        finish_load("t2");

        // N = 1025 rejected, N = 1024 fills the memory
        pulse_start();
        s = '{8'h01, 8'h04};
        send_stream(1'b0, -1);
        check1("t3_err", err, 1'b1);
        pulse_start();
        build_words(1024, 32'h1234_5678);
        act_q.delete();
        send_stream(1'b0, -1);
        finish_load("t3");
        check("t3_nwr", 32'(act_q.size()), 32'd1024);
        if (act_q.size() > 0) check("t3_last_addr", act_q[$].a, 32'h0000_0FFC);

        // stalls on byte_valid must not change the writes
        pulse_start();
        build_words(3, 32'hA5A5_0F0F);
        act_q.delete();
        send_stream(1'b1, -1);
        finish_load("t4");
        check("t4_nwr", 32'(act_q.size()), 32'd3);

        // start in DONE begins a reload; reset after the 6th data byte
        pulse_start();
        check1("t5_hold_reasserted", core_hold, 1'b1);
        check1("t5_busy", busy, 1'b1);
        check1("t5_done_cleared", done, 1'b0);
        build_words(3, 32'h0BAD_F00D);
        s = s[0:7];
        send_stream(1'b0, -1);
        rst = 1'b1;
        #1;
        check1("t5_rst_busy", busy, 1'b0);
        check1("t5_rst_hold", core_hold, 1'b1);
        check1("t5_rst_ready", byte_ready, 1'b0);
        check1("t5_rst_wr_en", wr_en, 1'b0);
        check("t5_rst_wr_addr", wr_addr, 32'd0);
        check("t5_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        pulse_start();
        build_words(2, 32'h5555_AAAA);
        act_q.delete();
        send_stream(1'b0, -1);
        finish_load("t5");
        if (act_q.size() > 0) check("t5_first_addr", act_q[0].a, 32'h0);

        // start during DATA is ignored
        pulse_start();
        build_words(3, 32'h7777_1111);
        act_q.delete();
        send_stream(1'b0, 5);
        finish_load("t6");
        check("t6_nwr", 32'(act_q.size()), 32'd3);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
